// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter (and the future
//                receiver): FSM state encoding and the oversampling factor.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Oversample ticks per serial bit.
    localparam int OVERSAMPLE = 16;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_rate_gen
//  Description : Free-running divider producing a one-clk oversample tick
//                every BAUD_DIV clocks. 'restart' realigns the divider so the
//                first tick of a frame lands exactly BAUD_DIV clks later.
//  Ports       : clk     - system clock
//                reset   - asynchronous, active-low reset
//                restart - synchronous clear of the divider
//                s_tick  - one-clk pulse when the divider wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_rate_gen #(
    parameter int BAUD_DIV = 326
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic s_tick
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (restart) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign s_tick = (div_cnt_q == DIV_LAST);

endmodule : baud_rate_gen
`default_nettype wire

// File: rtl/alu_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_tx
//  Description : 8N1-style serial transmitter for the ALU result word. The
//                word is latched on a tx_start pulse and shifted out LSB first
//                behind a start bit and followed by a stop bit, using a 16x
//                oversample tick from baud_rate_gen.
//  Ports       : clk          - system clock
//                reset        - asynchronous, active-low reset
//                data_in      - word to send (ALU result)
//                tx_start     - request to send data_in (honoured in IDLE)
//                tx           - serial line, idles high, registered
//                tx_busy      - high while a frame is in flight
//                tx_done_tick - one-clk pulse on the last stop-bit tick
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_tx
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int BAUD_DIV    = 326,
    parameter int SB_TICKS    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   tx_start,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done_tick
);

    localparam int TICK_W = 4;
    localparam int BIT_W  = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_LENGTH - 1);

    state_t                   state_q, state_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_LENGTH-1:0]   shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     restart;
    logic                     s_tick;
    logic                     done;

    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .s_tick  (s_tick)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        restart   = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d   = data_in;
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_d  = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is derived from the *next* state so the registered
        // tx changes on the same edge as the state, one clk after acceptance.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    // Combinational so the pulse coincides with the last STOP cycle; a
    // tx_start in that cycle is therefore still seen in STOP and dropped.
    assign tx_done_tick = done;

endmodule : alu_result_tx
`default_nettype wire
